// File: rtl/gsim_residual_chk.sv
// Residual checker downstream of the GSIM solver: captures b and x, recomputes r = A*x - b
// for the fixed 16x16 banded matrix, streams r and a max-|r| pass/fail verdict. Option: RESID_SQ_EN.
module gsim_residual_chk #(
  parameter int unsigned N   = 16,
  parameter logic [31:0] TOL = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [15:0] b_in,
  input  logic        out_valid,
  input  logic [31:0] x_out,
  output logic        r_valid,
  output logic [31:0] r_out,
  output logic [3:0]  r_idx,
  output logic        done,
  output logic [31:0] max_abs,
  output logic        pass
`ifdef RESID_SQ_EN
  ,
  output logic [47:0] sq_sum
`endif
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned LAST_T = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_DONE
  } state_e;

  state_e                   state_q;
  logic [CNT_W-1:0]         bcnt_q, bcnt_d;
  logic [CNT_W-1:0]         xcnt_q, xcnt_d;
  logic [15:0]              b_buf [N];
  logic [31:0]              x_buf [N];
  logic [3:0]               row_q;
  logic [2:0]               tap_q;
  logic signed [ACC_W-1:0]  acc_q;

  logic                     trig_c;
  logic                     b_we_c, x_we_c;
  logic [3:0]               b_widx_c, x_widx_c;
  logic signed [5:0]        k_c;
  logic                     k_ok_c;
  logic signed [ACC_W-1:0]  coef_c, xs_c, prod_c;
  logic signed [ACC_W-1:0]  bsh_c, diff_c;
  logic [31:0]              r_sat_c, r_abs_c, max_next_c;

  assign trig_c = in_en | out_valid;

  // Capture enables: open while filling, and the DONE->LOAD trigger sample lands at index 0
  always_comb begin
    b_we_c   = 1'b0;
    x_we_c   = 1'b0;
    b_widx_c = bcnt_q[3:0];
    x_widx_c = xcnt_q[3:0];
    bcnt_d   = bcnt_q;
    xcnt_d   = xcnt_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        b_we_c = in_en && (bcnt_q != CNT_W'(N));
        x_we_c = out_valid && (xcnt_q != CNT_W'(N));
        bcnt_d = bcnt_q + CNT_W'(b_we_c);
        xcnt_d = xcnt_q + CNT_W'(x_we_c);
      end
      S_DONE: begin
        b_we_c   = in_en;
        x_we_c   = out_valid;
        b_widx_c = 4'd0;
        x_widx_c = 4'd0;
        if (trig_c) begin
          bcnt_d = CNT_W'(in_en);
          xcnt_d = CNT_W'(out_valid);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (b_we_c) b_buf[b_widx_c] <= b_in;
    if (x_we_c) x_buf[x_widx_c] <= x_out;
  end

  // One MAC tap: column k = row + tap - 3; out-of-range columns contribute zero
  always_comb begin
    k_c    = $signed({2'b00, row_q}) + $signed({3'b000, tap_q}) - 6'sd3;
    k_ok_c = !k_c[5] && !k_c[4];
    case (tap_q)
      3'd0, 3'd6: coef_c = -40'sd1;
      3'd1, 3'd5: coef_c = 40'sd6;
      3'd2, 3'd4: coef_c = -40'sd13;
      3'd3:       coef_c = 40'sd20;
      default:    coef_c = 40'sd0;
    endcase
    xs_c   = ACC_W'($signed(x_buf[k_c[3:0]]));
    prod_c = k_ok_c ? (coef_c * xs_c) : '0;
  end

  // Emit path: subtract b in Q16.16, saturate to 32-bit signed, track max magnitude
  always_comb begin
    bsh_c  = {{8{b_buf[row_q][15]}}, b_buf[row_q], 16'h0000};
    diff_c = acc_q - bsh_c;
    if ((diff_c[39:31] == 9'h000) || (diff_c[39:31] == 9'h1FF)) begin
      r_sat_c = diff_c[31:0];
    end else if (diff_c[39]) begin
      r_sat_c = 32'h8000_0000;
    end else begin
      r_sat_c = 32'h7FFF_FFFF;
    end
    if (r_sat_c == 32'h8000_0000) begin
      r_abs_c = 32'h7FFF_FFFF;
    end else if (r_sat_c[31]) begin
      r_abs_c = -r_sat_c;
    end else begin
      r_abs_c = r_sat_c;
    end
    max_next_c = (r_abs_c > max_abs) ? r_abs_c : max_abs;
  end

`ifdef RESID_SQ_EN
  logic signed [63:0] sq_prod_c;
  logic [47:0]        sq_term_c;
  logic [48:0]        sq_add_c;
  logic [47:0]        sq_next_c;

  always_comb begin
    sq_prod_c = 64'($signed(r_sat_c)) * 64'($signed(r_sat_c));
    sq_term_c = 48'(sq_prod_c >>> 16);
    sq_add_c  = {1'b0, sq_sum} + {1'b0, sq_term_c};
    sq_next_c = sq_add_c[48] ? '1 : sq_add_c[47:0];
  end
`endif

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      xcnt_q  <= '0;
      row_q   <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      r_valid <= 1'b0;
      r_out   <= '0;
      r_idx   <= '0;
      done    <= 1'b0;
      max_abs <= '0;
      pass    <= 1'b0;
`ifdef RESID_SQ_EN
      sq_sum  <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      bcnt_q  <= bcnt_d;
      xcnt_q  <= xcnt_d;
      case (state_q)
        S_IDLE: begin
          if (trig_c) state_q <= S_LOAD;
        end
        S_LOAD: begin
          if ((bcnt_d == CNT_W'(N)) && (xcnt_d == CNT_W'(N))) begin
            state_q <= S_CALC;
            row_q   <= '0;
            tap_q   <= '0;
            acc_q   <= '0;
          end
        end
        S_CALC: begin
          if (tap_q != 3'(LAST_T)) begin
            acc_q <= acc_q + prod_c;
            tap_q <= tap_q + 3'd1;
          end else begin
            r_out   <= r_sat_c;
            r_valid <= 1'b1;
            r_idx   <= row_q;
            max_abs <= max_next_c;
`ifdef RESID_SQ_EN
            sq_sum  <= sq_next_c;
`endif
            acc_q   <= '0;
            tap_q   <= '0;
            row_q   <= row_q + 4'd1;
            if (row_q == 4'(N - 1)) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (trig_c) begin
            state_q <= S_LOAD;
            done    <= 1'b0;
            pass    <= 1'b0;
            max_abs <= '0;
`ifdef RESID_SQ_EN
            sq_sum  <= '0;
`endif
          end else begin
            done <= 1'b1;
            pass <= (max_abs <= TOL);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
